// File: rtl/add_sub_reservation_station.sv
// rtl/add_sub_reservation_station.sv - reservation station feeding the add/sub execution unit
package add_sub_rs_pkg;
    typedef struct packed {
        logic subtract;
        logic carry_en;
        logic record_ca;
    } add_sub_decode_t;
endpackage

module add_sub_reservation_station
    import add_sub_rs_pkg::*;
#(
    parameter int RS_ENTRIES  = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [31:0]            op1_in,
    input  logic [31:0]            op2_in,
    input  logic                   op1_valid,
    input  logic                   op2_valid,
    input  logic [RS_ID_WIDTH-1:0] op1_tag,
    input  logic [RS_ID_WIDTH-1:0] op2_tag,
    input  logic                   carry_in,
    input  logic                   carry_valid,
    input  logic [RS_ID_WIDTH-1:0] carry_tag,
    input  add_sub_decode_t        control_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    input  logic                   cdb_ca,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            op1,
    output logic [31:0]            op2,
    output logic                   carry_out,
    output add_sub_decode_t        control_out
);

    localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

    logic [RS_ENTRIES-1:0]  busy;
    logic [RS_ENTRIES-1:0]  op1_vld;
    logic [RS_ENTRIES-1:0]  op2_vld;
    logic [RS_ENTRIES-1:0]  ca_vld;
    logic [RS_ENTRIES-1:0]  ca_val;
    logic [31:0]            op1_val [RS_ENTRIES];
    logic [31:0]            op2_val [RS_ENTRIES];
    logic [RS_ID_WIDTH-1:0] op1_tg  [RS_ENTRIES];
    logic [RS_ID_WIDTH-1:0] op2_tg  [RS_ENTRIES];
    logic [RS_ID_WIDTH-1:0] ca_tg   [RS_ENTRIES];
    add_sub_decode_t        ctrl    [RS_ENTRIES];
    logic [4:0]             rd      [RS_ENTRIES];

    logic [RS_ENTRIES-1:0] ready;
    logic [IDX_W-1:0]      alloc_idx;
    logic [IDX_W-1:0]      issue_idx;
    logic                  dispatch_fire;
    logic                  issue_fire;
    logic                  fwd_op1;
    logic                  fwd_op2;
    logic                  fwd_ca;

    assign ready          = busy & op1_vld & op2_vld & ca_vld;
    assign dispatch_ready = |(~busy);
    assign issue_valid    = |ready;
    assign dispatch_fire  = dispatch_valid & dispatch_ready;
    assign issue_fire     = issue_valid & issue_ready;

    // Operands arriving on the CDB in the dispatch cycle are captured directly.
    assign fwd_op1 = !op1_valid   && cdb_valid && (cdb_rs_id == op1_tag);
    assign fwd_op2 = !op2_valid   && cdb_valid && (cdb_rs_id == op2_tag);
    assign fwd_ca  = !carry_valid && cdb_valid && (cdb_rs_id == carry_tag);

    // Descending scan so the lowest index wins for both allocation and issue.
    always_comb begin
        alloc_idx = '0;
        issue_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = IDX_W'(i);
            if (ready[i]) issue_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= '0;
            op1_vld <= '0;
            op2_vld <= '0;
            ca_vld  <= '0;
            ca_val  <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                op1_val[i] <= '0;
                op2_val[i] <= '0;
                op1_tg[i]  <= '0;
                op2_tg[i]  <= '0;
                ca_tg[i]   <= '0;
                ctrl[i]    <= '0;
                rd[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (issue_fire && issue_idx == IDX_W'(i)) busy[i] <= 1'b0;

                if (busy[i] && cdb_valid) begin
                    if (!op1_vld[i] && op1_tg[i] == cdb_rs_id) begin
                        op1_val[i] <= cdb_result;
                        op1_vld[i] <= 1'b1;
                    end
                    if (!op2_vld[i] && op2_tg[i] == cdb_rs_id) begin
                        op2_val[i] <= cdb_result;
                        op2_vld[i] <= 1'b1;
                    end
                    if (!ca_vld[i] && ca_tg[i] == cdb_rs_id) begin
                        ca_val[i] <= cdb_ca;
                        ca_vld[i] <= 1'b1;
                    end
                end

                // The allocated entry was free, so it never collides with the snoop above.
                if (dispatch_fire && alloc_idx == IDX_W'(i)) begin
                    busy[i]    <= 1'b1;
                    op1_val[i] <= op1_valid   ? op1_in   : cdb_result;
                    op2_val[i] <= op2_valid   ? op2_in   : cdb_result;
                    ca_val[i]  <= carry_valid ? carry_in : cdb_ca;
                    op1_vld[i] <= op1_valid   | fwd_op1;
                    op2_vld[i] <= op2_valid   | fwd_op2;
                    ca_vld[i]  <= carry_valid | fwd_ca;
                    op1_tg[i]  <= op1_tag;
                    op2_tg[i]  <= op2_tag;
                    ca_tg[i]   <= carry_tag;
                    ctrl[i]    <= control_in;
                    rd[i]      <= result_reg_addr_in;
                end
            end
        end
    end

    always_comb begin
        rs_id_out           = '0;
        result_reg_addr_out = '0;
        op1                 = '0;
        op2                 = '0;
        carry_out           = 1'b0;
        control_out         = '0;
        if (issue_valid) begin
            rs_id_out           = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(issue_idx);
            result_reg_addr_out = rd[issue_idx];
            op1                 = op1_val[issue_idx];
            op2                 = op2_val[issue_idx];
            carry_out           = ca_val[issue_idx];
            control_out         = ctrl[issue_idx];
        end
    end

endmodule

// File: tb/tb_add_sub_reservation_station.sv
// tb/tb_add_sub_reservation_station.sv - bench for add_sub_reservation_station
module tb_add_sub_reservation_station;
    import add_sub_rs_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 5;
    localparam int OFS = 0;

    logic clk = 1'b0;
    logic rst;
    logic dispatch_valid, dispatch_ready;
    logic [31:0] op1_in, op2_in;
    logic op1_valid, op2_valid;
    logic [IDW-1:0] op1_tag, op2_tag;
    logic carry_in, carry_valid;
    logic [IDW-1:0] carry_tag;
    add_sub_decode_t control_in;
    logic [4:0] result_reg_addr_in;
    logic cdb_valid;
    logic [IDW-1:0] cdb_rs_id;
    logic [31:0] cdb_result;
    logic cdb_ca;
    logic issue_valid, issue_ready;
    logic [IDW-1:0] rs_id_out;
    logic [4:0] result_reg_addr_out;
    logic [31:0] op1, op2;
    logic carry_out;
    add_sub_decode_t control_out;

    int n_pass = 0;
    int n_total = 0;

    add_sub_reservation_station #(.RS_ENTRIES(N), .RS_ID_WIDTH(IDW), .RS_OFFSET(OFS)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .op1_in(op1_in), .op2_in(op2_in), .op1_valid(op1_valid), .op2_valid(op2_valid),
        .op1_tag(op1_tag), .op2_tag(op2_tag),
        .carry_in(carry_in), .carry_valid(carry_valid), .carry_tag(carry_tag),
        .control_in(control_in), .result_reg_addr_in(result_reg_addr_in),
        .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result), .cdb_ca(cdb_ca),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .rs_id_out(rs_id_out),
        .result_reg_addr_out(result_reg_addr_out), .op1(op1), .op2(op2),
        .carry_out(carry_out), .control_out(control_out)
    );

    always #5 clk = ~clk;

    // Reference model: each slot holds three operands (op1, op2, carry in bit 0).
    bit              m_busy [N];
    bit              m_ok   [N][3];
    logic [31:0]     m_val  [N][3];
    logic [IDW-1:0]  m_tag  [N][3];
    add_sub_decode_t m_ctrl [N];
    logic [4:0]      m_rd   [N];

    function automatic int m_first_ready();
        for (int i = 0; i < N; i++)
            if (m_busy[i] && m_ok[i][0] && m_ok[i][1] && m_ok[i][2]) return i;
        return -1;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        int sel, fr;
        logic [31:0] iv [3];
        bit ivl [3];
        logic [IDW-1:0] it [3];
        logic [31:0] cv [3];
        bit was_busy [N];
        sel = m_first_ready();
        fr  = m_first_free();
        iv = '{op1_in, op2_in, {31'b0, carry_in}};
        ivl = '{op1_valid, op2_valid, carry_valid};
        it = '{op1_tag, op2_tag, carry_tag};
        cv = '{cdb_result, cdb_result, {31'b0, cdb_ca}};
        for (int i = 0; i < N; i++) was_busy[i] = m_busy[i];
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0; m_ctrl[i] = '0; m_rd[i] = '0;
                for (int k = 0; k < 3; k++) begin m_ok[i][k] = 0; m_val[i][k] = '0; m_tag[i][k] = '0; end
            end
        end else begin
            if (issue_ready && sel >= 0) m_busy[sel] = 0;
            if (cdb_valid)
                for (int i = 0; i < N; i++)
                    if (was_busy[i])
                        for (int k = 0; k < 3; k++)
                            if (!m_ok[i][k] && m_tag[i][k] == cdb_rs_id) begin
                                m_ok[i][k] = 1; m_val[i][k] = cv[k];
                            end
            if (dispatch_valid && fr >= 0) begin
                m_busy[fr] = 1; m_ctrl[fr] = control_in; m_rd[fr] = result_reg_addr_in;
                for (int k = 0; k < 3; k++) begin
                    m_tag[fr][k] = it[k];
                    if (ivl[k]) begin m_ok[fr][k] = 1; m_val[fr][k] = iv[k]; end
                    else if (cdb_valid && cdb_rs_id == it[k]) begin m_ok[fr][k] = 1; m_val[fr][k] = cv[k]; end
                    else m_ok[fr][k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid = 0; op1_in = '0; op2_in = '0; op1_valid = 1; op2_valid = 1;
        op1_tag = '0; op2_tag = '0; carry_in = 0; carry_valid = 1; carry_tag = '0;
        control_in = '0; result_reg_addr_in = '0;
        cdb_valid = 0; cdb_rs_id = '0; cdb_result = '0; cdb_ca = 0; issue_ready = 0;
    endtask

    task automatic set_dispatch(input logic [31:0] a, input bit av, input logic [IDW-1:0] at,
                                input logic [31:0] b, input bit bv, input logic [IDW-1:0] bt,
                                input bit c, input bit cvld, input logic [IDW-1:0] ct);
        dispatch_valid = 1; op1_in = a; op1_valid = av; op1_tag = at;
        op2_in = b; op2_valid = bv; op2_tag = bt;
        carry_in = c; carry_valid = cvld; carry_tag = ct;
    endtask

    task automatic cdb(input logic [IDW-1:0] id, input logic [31:0] r, input bit ca);
        cdb_valid = 1; cdb_rs_id = id; cdb_result = r; cdb_ca = ca;
    endtask

    task automatic test_reset();
        rst = 0; tick(); tick(); rst = 1;
        n_total++; if (dispatch_ready !== 1'b1) $display("FAIL reset_dready got %0b want 1", dispatch_ready); else n_pass++;
        n_total++; if (issue_valid !== 1'b0) $display("FAIL reset_ivalid got %0b want 0", issue_valid); else n_pass++;
        n_total++; if ({rs_id_out, result_reg_addr_out, op1, op2, carry_out, control_out} !== '0)
            $display("FAIL reset_outputs got op1=%h op2=%h rs=%0d want all 0", op1, op2, rs_id_out); else n_pass++;
    endtask

    task automatic test_basic();
        set_dispatch(5, 1, 0, 7, 1, 0, 0, 1, 0);
        control_in = '{subtract: 1'b0, carry_en: 1'b1, record_ca: 1'b0}; result_reg_addr_in = 5'd12;
        tick(); idle_inputs();
        n_total++; if (issue_valid !== 1'b1) $display("FAIL basic_ivalid got %0b want 1", issue_valid); else n_pass++;
        n_total++; if (rs_id_out !== IDW'(OFS)) $display("FAIL basic_rsid got %0d want %0d", rs_id_out, OFS); else n_pass++;
        n_total++; if (op1 !== 32'd5 || op2 !== 32'd7 || carry_out !== 1'b0)
            $display("FAIL basic_ops got %0d/%0d/%0b want 5/7/0", op1, op2, carry_out); else n_pass++;
        n_total++; if (result_reg_addr_out !== 5'd12 || control_out !== 3'b010)
            $display("FAIL basic_rd_ctrl got %0d/%b want 12/010", result_reg_addr_out, control_out); else n_pass++;
        issue_ready = 1; tick(); issue_ready = 0;
        n_total++; if (issue_valid !== 1'b0) $display("FAIL basic_freed got %0b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_tag_wait();
        set_dispatch(1, 1, 0, 0, 0, 9, 0, 1, 0); tick(); idle_inputs();
        for (int c = 0; c < 3; c++) begin
            n_total++; if (issue_valid !== 1'b0) $display("FAIL tagwait_hold%0d got %0b want 0", c, issue_valid); else n_pass++;
            tick();
        end
        cdb(9, 32'h1234, 0); tick(); idle_inputs();
        n_total++; if (issue_valid !== 1'b1 || op2 !== 32'h1234)
            $display("FAIL tagwait_capture got v=%0b op2=%h want 1/1234", issue_valid, op2); else n_pass++;
        issue_ready = 1; tick(); issue_ready = 0;
    endtask

    task automatic test_forward();
        set_dispatch(2, 1, 0, 3, 1, 0, 0, 0, 3); cdb(3, 32'hdead, 1); tick(); idle_inputs();
        n_total++; if (issue_valid !== 1'b1 || carry_out !== 1'b1)
            $display("FAIL forward got v=%0b ca=%0b want 1/1", issue_valid, carry_out); else n_pass++;
        issue_ready = 1; tick(); issue_ready = 0;
    endtask

    task automatic test_full();
        for (int i = 0; i < N; i++) begin set_dispatch(i + 1, 1, 0, 0, 1, 0, 0, 1, 0); tick(); end
        n_total++; if (dispatch_ready !== 1'b0) $display("FAIL full_dready got %0b want 0", dispatch_ready); else n_pass++;
        set_dispatch(32'hAA, 1, 0, 0, 1, 0, 0, 1, 0); issue_ready = 1; tick(); issue_ready = 0;
        n_total++; if (dispatch_ready !== 1'b1 || rs_id_out !== IDW'(OFS + 1) || op1 !== 32'd2)
            $display("FAIL full_issue0 got dr=%0b rs=%0d op1=%0d want 1/%0d/2", dispatch_ready, rs_id_out, op1, OFS + 1); else n_pass++;
        tick(); dispatch_valid = 0;
        n_total++; if (rs_id_out !== IDW'(OFS) || op1 !== 32'hAA)
            $display("FAIL full_refill got rs=%0d op1=%h want %0d/aa", rs_id_out, op1, OFS); else n_pass++;
        issue_ready = 1; for (int i = 0; i < N; i++) tick(); issue_ready = 0;
        n_total++; if (issue_valid !== 1'b0) $display("FAIL full_drain got %0b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_priority();
        set_dispatch(0, 0, 20, 0, 1, 0, 0, 1, 0); tick();
        set_dispatch(0, 0, 11, 1, 1, 0, 0, 1, 0); tick();
        set_dispatch(0, 0, 12, 2, 1, 0, 0, 1, 0); tick(); idle_inputs();
        cdb(12, 32'h22, 0); tick(); idle_inputs();
        n_total++; if (rs_id_out !== IDW'(OFS + 2)) $display("FAIL prio_e2 got %0d want %0d", rs_id_out, OFS + 2); else n_pass++;
        cdb(11, 32'h11, 0); tick(); idle_inputs();
        n_total++; if (rs_id_out !== IDW'(OFS + 1) || op1 !== 32'h11)
            $display("FAIL prio_e1 got rs=%0d op1=%h want %0d/11", rs_id_out, op1, OFS + 1); else n_pass++;
        issue_ready = 1; tick();
        n_total++; if (rs_id_out !== IDW'(OFS + 2) || op1 !== 32'h22)
            $display("FAIL prio_second got rs=%0d op1=%h want %0d/22", rs_id_out, op1, OFS + 2); else n_pass++;
        tick();
        n_total++; if (issue_valid !== 1'b0) $display("FAIL prio_empty got %0b want 0", issue_valid); else n_pass++;
        cdb(20, 32'h0, 0); tick(); idle_inputs(); issue_ready = 1; tick(); issue_ready = 0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin set_dispatch(i, 0, IDW'(21 + i), 0, 1, 0, 0, 1, 0); tick(); end
        idle_inputs(); rst = 0; tick(); rst = 1;
        n_total++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1)
            $display("FAIL rstmid got v=%0b dr=%0b want 0/1", issue_valid, dispatch_ready); else n_pass++;
        cdb(21, 32'h5, 1); tick(); idle_inputs();
        n_total++; if (issue_valid !== 1'b0 || op1 !== 32'h0)
            $display("FAIL rstmid_cdb got v=%0b op1=%h want 0/0", issue_valid, op1); else n_pass++;
    endtask

    task automatic test_random();
        int s;
        for (int c = 0; c < 400; c++) begin
            dispatch_valid = ($urandom_range(0, 2) != 0);
            op1_in = $urandom; op2_in = $urandom; carry_in = 1'($urandom);
            op1_valid = 1'($urandom); op2_valid = 1'($urandom); carry_valid = 1'($urandom);
            op1_tag = IDW'($urandom_range(0, 7)); op2_tag = IDW'($urandom_range(0, 7));
            carry_tag = IDW'($urandom_range(0, 7));
            control_in = add_sub_decode_t'($urandom_range(0, 7));
            result_reg_addr_in = 5'($urandom);
            cdb_valid = 1'($urandom); cdb_rs_id = IDW'($urandom_range(0, 7));
            cdb_result = $urandom; cdb_ca = 1'($urandom);
            issue_ready = 1'($urandom);
            tick();
            s = m_first_ready();
            n_total++; if (dispatch_ready !== (m_first_free() >= 0))
                $display("FAIL rand_dready c=%0d got %0b want %0b", c, dispatch_ready, m_first_free() >= 0); else n_pass++;
            n_total++; if (issue_valid !== (s >= 0))
                $display("FAIL rand_ivalid c=%0d got %0b want %0b", c, issue_valid, s >= 0); else n_pass++;
            if (s >= 0) begin
                n_total++;
                if (rs_id_out !== IDW'(OFS + s) || op1 !== m_val[s][0] || op2 !== m_val[s][1] ||
                    carry_out !== m_val[s][2][0] || control_out !== m_ctrl[s] || result_reg_addr_out !== m_rd[s])
                    $display("FAIL rand_issue c=%0d got rs=%0d op1=%h op2=%h ca=%0b ctl=%b rd=%0d want rs=%0d op1=%h op2=%h ca=%0b ctl=%b rd=%0d",
                             c, rs_id_out, op1, op2, carry_out, control_out, result_reg_addr_out,
                             OFS + s, m_val[s][0], m_val[s][1], m_val[s][2][0], m_ctrl[s], m_rd[s]);
                else n_pass++;
            end else begin
                n_total++; if ({rs_id_out, result_reg_addr_out, op1, op2, carry_out, control_out} !== '0)
                    $display("FAIL rand_zero c=%0d got op1=%h op2=%h rs=%0d want 0", c, op1, op2, rs_id_out); else n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        test_basic();
        test_tag_wait();
        test_forward();
        test_full();
        test_priority();
        test_reset_mid();
        rst = 0; tick(); rst = 1;
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
